pred_argmax_reader: RTL and testbench
=====================================

Name: pred_argmax_reader

Overview:
- Consumer at the output end of the CNN classifier pipeline.
- Accepts one prediction vector per vld_in pulse: NUM_CLASSES signed logits, BW bits each, in the same layout as the classifier's data_out.
- Serially scans the vector, one lane per cycle, to find the winning class. Presents class index and max logit to downstream logic with a valid/ready handshake.
- The classifier output has no backpressure, so frames arriving while busy are dropped and counted.

Parameters:
- NUM_CLASSES, 24, number of logits per frame (>=2).
- BW, 10, logit width; two's-complement signed.
- CNT_W, 16, width of the dropped-frame counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- vld_in  input  1  single-cycle strobe; data_in valid this cycle.
- data_in  input  [BW-1:0] x NUM_CLASSES (unpacked [NUM_CLASSES-1:0])  logit vector; element i = class i.
- rdy_in  input  1  downstream ready for result.
- vld_out  output  1  result valid; held until accepted.
- class_out  output  $clog2(NUM_CLASSES)  index of max logit.
- max_out  output  BW  max logit value (signed).
- busy  output  1  high in SCAN or HOLD.
- drop_cnt  output  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, vld_out=0, class_out=0, max_out=0, busy=0, drop_cnt=0.
  - The capture register is not required to reset.
  - Takes effect immediately, including mid-SCAN or mid-HOLD; the in-flight frame is discarded.
- IDLE:
  - On vld_in, capture all of data_in.
  - Set best_idx=0, best_val=data_in[0], scan_idx=1. Go to SCAN.
- SCAN:
  - Each cycle, compare lane scan_idx (signed) against best_val.
  - If strictly greater, replace best_val and best_idx. Ties keep the lower index.
  - scan_idx increments by 1 each cycle.
  - After processing lane NUM_CLASSES-1, go to HOLD. class_out=best_idx, max_out=best_val, vld_out=1, all registered.
- Latency:
  - vld_out rises NUM_CLASSES-1 cycles after the capture edge (23 at default).
- HOLD:
  - vld_out, class_out and max_out stay stable until vld_out && rdy_in at a clock edge.
  - On accept, vld_out falls next cycle and state=IDLE.
  - If vld_in coincides with the accept edge, the new frame is captured and state goes directly to SCAN. No frame is dropped and there is no bubble.
  - Minimum frame period is NUM_CLASSES cycles.
- Drop rule:
  - vld_in in SCAN, or in HOLD without an accept that cycle, is ignored.
  - drop_cnt increments by 1 and saturates at all-ones.
  - The result of the frame in flight is unaffected.
- busy:
  - busy = (state != IDLE), registered with state.
  - It is informational only; upstream is not required to honour it.
- Comparison:
  - Full-width signed compare. 0x200 (-512) is the minimum and 0x1FF (+511) the maximum at BW=10.
  - No arithmetic overflow is possible.
- rdy_in while vld_out=0 has no effect.
- data_in is sampled only on capture edges.

Test Plan:
- Nominal frame: data_in[23..0] = {36c,3a5,3a9,364,31e,34a,34c,358,387,3a9,3a9,3a5,39a,3a1,3b0,3af,3ae,3ef,007,336,357,2df,32f,2f5}, rdy_in=1 -> vld_out high 23 cycles after capture for exactly 1 cycle; class_out=5, max_out=0x007; drop_cnt=0.
- Ties and signedness:
  - All lanes 0x3FF -> class_out=0, max_out=0x3FF.
  - Lane0=0x200, lane23=0x1FF, others 0x000 -> class_out=23, max_out=0x1FF.
  - Lanes 3 and 17 both 0x100, others 0x000 -> class_out=3.
- Backpressure: nominal frame with rdy_in=0 for 10 cycles after vld_out rises, then 1 -> outputs constant for all 11 HOLD cycles; vld_out drops the cycle after accept; state IDLE.
- Drops: vld_in pulses 5 cycles into SCAN and again during a stalled HOLD -> drop_cnt=2; original result (class 5) delivered intact. With CNT_W=2, 5 drops -> drop_cnt=3.
- Back-to-back: vld_in every 24 cycles with rdy_in=1, alternating the nominal frame and the lane23=0x1FF frame -> results 5, 23, 5, 23 with no drops. Period 23 cycles -> every second frame is dropped and drop_cnt counts them.
- Reset mid-operation: assert rst low 10 cycles into SCAN, asynchronously between edges -> vld_out=0, busy=0, drop_cnt=0 immediately. After release, the nominal frame gives class_out=5 at normal latency.

Source files
------------

// File: rtl/pred_argmax_reader.sv
// Serial argmax over one captured prediction vector. The result is held behind
// a valid/ready handshake, and frames that arrive while busy are dropped and counted.
module pred_argmax_reader #(
  parameter int NUM_CLASSES = 24,
  parameter int BW          = 10,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [BW-1:0]    data_in [NUM_CLASSES-1:0],
  input  logic             rdy_in,
  output logic             vld_out,
  output logic [IDX_W-1:0] class_out,
  output logic [BW-1:0]    max_out,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    capture_q [NUM_CLASSES-1:0];
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [BW-1:0]    best_val_q, best_val_d;
  logic [IDX_W-1:0] class_q, class_d;
  logic [BW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             accept;
  logic             capture_en;
  logic             drop;
  logic             last_lane;
  logic [BW-1:0]    lane_val;
  logic             lane_wins;
  logic [IDX_W-1:0] cand_idx;
  logic [BW-1:0]    cand_val;

  // A frame is taken in IDLE, or on the accept edge so back-to-back frames see no bubble.
  assign accept     = (state_q == HOLD) && rdy_in;
  assign capture_en = vld_in && ((state_q == IDLE) || accept);
  assign drop       = vld_in && !capture_en;

  assign last_lane  = (scan_idx_q == LAST_IDX);
  assign lane_val   = capture_q[scan_idx_q];
  // Strict compare so ties keep the lower index.
  assign lane_wins  = $signed(lane_val) > $signed(best_val_q);
  assign cand_idx   = lane_wins ? scan_idx_q : best_idx_q;
  assign cand_val   = lane_wins ? lane_val   : best_val_q;

  // Capture storage is deliberately left without reset.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_capture
      always_ff @(posedge clk) begin
        if (capture_en) begin
          capture_q[gi] <= data_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last_lane) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = capture_en ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_out   = (state_q == HOLD);
    busy      = (state_q != IDLE);
    class_out = class_q;
    max_out   = max_q;
    drop_cnt  = drop_cnt_q;
  end

  always_comb begin
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    class_d    = class_q;
    max_d      = max_q;
    if (capture_en) begin
      best_idx_d = '0;
      best_val_d = data_in[0];
      scan_idx_d = IDX_W'(1);
    end else if (state_q == SCAN) begin
      best_idx_d = cand_idx;
      best_val_d = cand_val;
      if (last_lane) begin
        class_d = cand_idx;
        max_d   = cand_val;
      end else begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      class_q    <= '0;
      max_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      class_q    <= class_d;
      max_q      <= max_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pred_argmax_reader.sv
// Directed bench for pred_argmax_reader: a second instance with a 2-bit
// drop counter shares all inputs so that saturation can be observed.
module tb_pred_argmax_reader;

  localparam int NC = 24;
  localparam int BW = 10;

  logic          clk;
  logic          rst;
  logic          vld_in;
  logic [BW-1:0] data_in [NC-1:0];
  logic          rdy_in;

  logic          vld_out, busy;
  logic [4:0]    class_out;
  logic [BW-1:0] max_out;
  logic [15:0]   drop_cnt;

  logic          vld_out2, busy2;
  logic [4:0]    class_out2;
  logic [BW-1:0] max_out2;
  logic [1:0]    drop_cnt2;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int results;

  pred_argmax_reader #(.NUM_CLASSES(NC), .BW(BW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .rdy_in(rdy_in),
    .vld_out(vld_out), .class_out(class_out), .max_out(max_out),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  pred_argmax_reader #(.NUM_CLASSES(NC), .BW(BW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .rdy_in(rdy_in),
    .vld_out(vld_out2), .class_out(class_out2), .max_out(max_out2),
    .busy(busy2), .drop_cnt(drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 0 nominal, 1 all 0x3FF, 2 lane0=-512/lane23=+511, 3 tie at lanes 3 and 17, 4 junk all 0x1FF
  task automatic set_frame(input int kind);
    case (kind)
      0: data_in = '{10'h36c, 10'h3a5, 10'h3a9, 10'h364, 10'h31e, 10'h34a, 10'h34c, 10'h358,
                     10'h387, 10'h3a9, 10'h3a9, 10'h3a5, 10'h39a, 10'h3a1, 10'h3b0, 10'h3af,
                     10'h3ae, 10'h3ef, 10'h007, 10'h336, 10'h357, 10'h2df, 10'h32f, 10'h2f5};
      1: for (int i = 0; i < NC; i++) data_in[i] = 10'h3ff;
      2: begin
        for (int i = 0; i < NC; i++) data_in[i] = 10'h000;
        data_in[0]  = 10'h200;
        data_in[23] = 10'h1ff;
      end
      3: begin
        for (int i = 0; i < NC; i++) data_in[i] = 10'h000;
        data_in[3]  = 10'h100;
        data_in[17] = 10'h100;
      end
      default: for (int i = 0; i < NC; i++) data_in[i] = 10'h1ff;
    endcase
  endtask

  task automatic send(input int kind);
    set_frame(kind);
    vld_in = 1'b1;
    cyc();
    vld_in = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (vld_out !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    rst    = 1'b0;
    vld_in = 1'b0;
    rdy_in = 1'b1;
    set_frame(0);
    cyc();
    cyc();
    chk("reset_vld", 32'(vld_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_class", 32'(class_out), 32'd0);
    chk("reset_max", 32'(max_out), 32'd0);
    chk("reset_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    cyc();

    // Nominal frame, always ready
    send(0);
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_vld_early", 32'(vld_out), 32'd0);
    wait_result(lat);
    chk("nom_latency", 32'(lat), 32'd23);
    chk("nom_class", 32'(class_out), 32'd5);
    chk("nom_max", 32'(max_out), 32'h007);
    chk("nom_drop", 32'(drop_cnt), 32'd0);
    cyc();
    chk("nom_vld_one_cycle", 32'(vld_out), 32'd0);
    chk("nom_idle", 32'(busy), 32'd0);

    // Ties and signed extremes
    send(1);
    wait_result(lat);
    chk("all3ff_class", 32'(class_out), 32'd0);
    chk("all3ff_max", 32'(max_out), 32'h3ff);
    cyc();
    send(2);
    wait_result(lat);
    chk("signed_class", 32'(class_out), 32'd23);
    chk("signed_max", 32'(max_out), 32'h1ff);
    cyc();
    send(3);
    wait_result(lat);
    chk("tie_class", 32'(class_out), 32'd3);
    chk("tie_max", 32'(max_out), 32'h100);
    cyc();

    // Backpressure: 10 stalled cycles then accept
    rdy_in = 1'b0;
    send(0);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd23);
    chk("bp_hold_class", 32'(class_out), 32'd5);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_hold_vld", 32'(vld_out), 32'd1);
      chk("bp_hold_class", 32'(class_out), 32'd5);
      chk("bp_hold_max", 32'(max_out), 32'h007);
    end
    rdy_in = 1'b1;
    cyc();
    chk("bp_vld_after_accept", 32'(vld_out), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    // Drops during SCAN and during a stalled HOLD
    rdy_in = 1'b0;
    send(0);
    repeat (4) cyc();
    set_frame(4);
    vld_in = 1'b1;
    cyc();
    vld_in = 1'b0;
    chk("drop_scan_cnt", 32'(drop_cnt), 32'd1);
    wait_result(lat);
    chk("drop_result_vld", 32'(vld_out), 32'd1);
    vld_in = 1'b1;
    cyc();
    vld_in = 1'b0;
    chk("drop_hold_cnt", 32'(drop_cnt), 32'd2);
    chk("drop_hold_cnt2", 32'(drop_cnt2), 32'd2);
    chk("drop_hold_vld", 32'(vld_out), 32'd1);
    chk("drop_result_class", 32'(class_out), 32'd5);
    chk("drop_result_max", 32'(max_out), 32'h007);
    rdy_in = 1'b1;
    cyc();
    chk("drop_accept_vld", 32'(vld_out), 32'd0);

    // Back-to-back at 24-cycle period, alternating frames
    for (int k = 0; k < 4; k++) begin
      set_frame((k % 2 == 0) ? 0 : 2);
      vld_in = 1'b1;
      cyc();
      vld_in = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      repeat (22) cyc();
      chk("b2b_vld_early", 32'(vld_out), 32'd0);
      cyc();
      chk("b2b_vld", 32'(vld_out), 32'd1);
      chk("b2b_class", 32'(class_out), (k % 2 == 0) ? 32'd5 : 32'd23);
    end
    cyc();
    chk("b2b_drop", 32'(drop_cnt), 32'd2);
    chk("b2b_idle", 32'(busy), 32'd0);

    // 23-cycle period: every second pulse lands on the last SCAN cycle
    results = 0;
    for (int k = 0; k < 6; k++) begin
      set_frame(0);
      vld_in = 1'b1;
      cyc();
      vld_in = 1'b0;
      if (vld_out === 1'b1) results++;
      for (int j = 0; j < 22; j++) begin
        cyc();
        if (vld_out === 1'b1) results++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (vld_out === 1'b1) results++;
    end
    chk("p23_results", 32'(results), 32'd3);
    chk("p23_drop", 32'(drop_cnt), 32'd5);
    chk("p23_drop_sat", 32'(drop_cnt2), 32'd3);

    // Asynchronous reset mid-SCAN
    send(0);
    repeat (10) cyc();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_vld", 32'(vld_out), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_drop", 32'(drop_cnt), 32'd0);
    chk("rst_async_drop2", 32'(drop_cnt2), 32'd0);
    cyc();
    #3;
    rst = 1'b1;
    cyc();
    send(0);
    wait_result(lat);
    chk("post_rst_latency", 32'(lat), 32'd23);
    chk("post_rst_class", 32'(class_out), 32'd5);
    chk("post_rst_max", 32'(max_out), 32'h007);
    cyc();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
